scanline_fill_engine: RTL
=========================

SCANLINE_FILL_ENGINE -- requirements
Module: scanline_fill_engine

Interface
REQ-001 Parameter ROW_PIX, default 64, pixels per row and width of the edge bitmap row; the block SHALL support any ROW_PIX >= 2.
REQ-002 Parameter NUM_ROWS, default 64, rows processed per fill job.
REQ-003 Parameter COLOR_W, default 24, bits per pixel colour.
REQ-004 Parameter NUM_LAYERS, default 2, number of target layer buffers; LW = max(1, clog2(NUM_LAYERS)).
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 n_rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  job request, sampled only in IDLE.
REQ-008 color  in  COLOR_W  fill colour, captured on accepted start.
REQ-009 layer  in  LW  target layer, captured on accepted start.
REQ-010 edge_req  out  1  request for edge row edge_row.
REQ-011 edge_row  out  clog2(NUM_ROWS)  row index being requested or processed.
REQ-012 edge_valid  in  1  edge_bits valid for edge_row.
REQ-013 edge_bits  in  ROW_PIX  edge bitmap; bit j = pixel j is an outline pixel.
REQ-014 wr_valid  out  1  row write offered.
REQ-015 wr_ready  in  1  layer writer accepts the offered row.
REQ-016 wr_layer  out  LW / wr_row  out  clog2(NUM_ROWS)  write destination.
REQ-017 wr_mask  out  ROW_PIX  per-pixel write enable.
REQ-018 wr_data  out  ROW_PIX*COLOR_W  pixel j at bits [j*COLOR_W +: COLOR_W].
REQ-019 busy  out  1  high in every state except IDLE; done  out  1  one-cycle job-complete pulse.

Function
REQ-020 FSM states SHALL be IDLE, REQ, SCAN, WRITE, DONE.
REQ-021 IDLE: start=1 -> capture color/layer, row counter=0, go REQ; start SHALL be ignored in all other states.
REQ-022 REQ: edge_req=1; on edge_valid=1 capture edge_bits, go SCAN; edge_valid outside REQ SHALL be ignored.
REQ-023 SCAN (exactly one cycle): a1 = lowest set bit index, a2 = highest set bit index; mask bits a1..a2 inclusive SHALL be 1, others 0; zero-bit row -> mask all 0; single set bit -> one-bit mask; go WRITE.
REQ-024 WRITE: wr_valid=1 with wr_layer, wr_row, wr_mask, wr_data held stable until wr_ready=1; wr_data SHALL hold the captured colour in every pixel slot.
REQ-025 On WRITE handshake: last row (NUM_ROWS-1) -> DONE, else row+1 -> REQ; row counter SHALL never wrap within a job.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 With edge_valid and wr_ready tied high, done SHALL assert 3*NUM_ROWS+1 cycles after the cycle start is sampled.
REQ-028 edge_req and wr_valid SHALL never be high in the same cycle.

Reset
REQ-029 n_rst=0 SHALL immediately force IDLE, row counter 0, captured colour/layer/mask 0, and all outputs 0 (busy, done, edge_req, wr_valid, wr_mask, wr_data, wr_row, wr_layer, edge_row).
REQ-030 Reset during a job SHALL abort it; no further wr_valid until a new start after reset release.

Configuration
REQ-031 Macro SCANLINE_FILL_SKIP_EMPTY_EN defined: a row whose mask is all 0 SHALL bypass WRITE (SCAN -> next REQ, or DONE if last row), emitting no write.
REQ-032 Macro undefined: every row, including all-0 mask rows, SHALL produce exactly one WRITE handshake (NUM_ROWS writes per job).

Verification
REQ-033 Defaults, start with color=0xFF8000, layer=1, row 5 edge_bits bits 10 and 20 set, other rows 0, ready/valid high -> row 5 wr_mask bits 10..20 set, wr_data slots = 0xFF8000, done at cycle 3*64+1.
REQ-034 edge_bits with only bit 63 set -> wr_mask = 1<<63; only bit 0 set -> wr_mask = 1.
REQ-035 wr_ready low 7 cycles during WRITE of row 3 -> wr_valid and all write outputs stable 7 cycles; row 4 requested only after handshake.
REQ-036 n_rst pulsed low during WRITE of row 10 -> all outputs 0 that cycle; no further writes; new start runs full job from row 0.
REQ-037 start held high continuously -> exactly one job per IDLE visit; start during busy has no effect on colour/layer.
REQ-038 All-zero edge rows: macro undefined -> 64 writes with wr_mask=0; macro defined -> 0 writes, done still pulses once.

Source files
------------

// File: rtl/scanline_fill_engine_if.sv
// rtl/scanline_fill_engine_if.sv - job, edge-fetch and row-write signals of the scanline fill engine
interface scanline_fill_engine_if #(
   parameter int ROW_PIX    = 64,
   parameter int NUM_ROWS   = 64,
   parameter int COLOR_W    = 24,
   parameter int NUM_LAYERS = 2
);
   localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   logic                       start;
   logic [COLOR_W-1:0]         color;
   logic [LW-1:0]              layer;
   logic                       edge_req;
   logic [RW-1:0]              edge_row;
   logic                       edge_valid;
   logic [ROW_PIX-1:0]         edge_bits;
   logic                       wr_valid;
   logic                       wr_ready;
   logic [LW-1:0]              wr_layer;
   logic [RW-1:0]              wr_row;
   logic [ROW_PIX-1:0]         wr_mask;
   logic [ROW_PIX*COLOR_W-1:0] wr_data;
   logic                       busy;
   logic                       done;

   modport master (
      output start, color, layer, edge_valid, edge_bits, wr_ready,
      input  edge_req, edge_row, wr_valid, wr_layer, wr_row, wr_mask, wr_data, busy, done
   );

   modport slave (
      input  start, color, layer, edge_valid, edge_bits, wr_ready,
      output edge_req, edge_row, wr_valid, wr_layer, wr_row, wr_mask, wr_data, busy, done
   );
endinterface

// File: rtl/scanline_fill_engine.sv
// rtl/scanline_fill_engine.sv - per-row edge fetch, outer-span fill mask and row write-back
// Optional feature macro SCANLINE_FILL_SKIP_EMPTY_EN: rows with an empty span issue no write.
module scanline_fill_engine #(
   parameter int ROW_PIX    = 64,
   parameter int NUM_ROWS   = 64,
   parameter int COLOR_W    = 24,
   parameter int NUM_LAYERS = 2
) (
   input logic                   clk,
   input logic                   n_rst,
   scanline_fill_engine_if.slave bus
);
   localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_SCAN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [RW-1:0]      row_q;
   logic [COLOR_W-1:0] color_q;
   logic [LW-1:0]      layer_q;
   logic [ROW_PIX-1:0] edge_q;
   logic [ROW_PIX-1:0] mask_q;
   logic               busy_q;
   logic               done_q;
   logic               edge_req_q;
   logic               wr_valid_q;

   logic [ROW_PIX-1:0] lo_seen_d;
   logic [ROW_PIX-1:0] hi_seen_d;
   logic [ROW_PIX-1:0] mask_d;
   logic               last_row;

   // A pixel lies in the span when an edge exists at or below it and at or above it.
   always_comb begin
      logic acc_lo;
      logic acc_hi;
      acc_lo    = 1'b0;
      acc_hi    = 1'b0;
      lo_seen_d = '0;
      hi_seen_d = '0;
      for (int j = 0; j < ROW_PIX; j++) begin
         acc_lo                 = acc_lo | edge_q[j];
         lo_seen_d[j]           = acc_lo;
         acc_hi                 = acc_hi | edge_q[ROW_PIX-1-j];
         hi_seen_d[ROW_PIX-1-j] = acc_hi;
      end
      mask_d = lo_seen_d & hi_seen_d;
   end

   assign last_row = (row_q == LAST_ROW);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         color_q    <= '0;
         layer_q    <= '0;
         edge_q     <= '0;
         mask_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         edge_req_q <= 1'b0;
         wr_valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  color_q    <= bus.color;
                  layer_q    <= bus.layer;
                  row_q      <= '0;
                  busy_q     <= 1'b1;
                  edge_req_q <= 1'b1;
                  state_q    <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.edge_valid) begin
                  edge_q     <= bus.edge_bits;
                  edge_req_q <= 1'b0;
                  state_q    <= S_SCAN;
               end
            end
            S_SCAN: begin
               mask_q <= mask_d;
`ifdef SCANLINE_FILL_SKIP_EMPTY_EN
               if (mask_d == '0) begin
                  if (last_row) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     row_q      <= row_q + RW'(1);
                     edge_req_q <= 1'b1;
                     state_q    <= S_REQ;
                  end
               end else begin
                  wr_valid_q <= 1'b1;
                  state_q    <= S_WRITE;
               end
`else
               wr_valid_q <= 1'b1;
               state_q    <= S_WRITE;
`endif
            end
            S_WRITE: begin
               if (bus.wr_ready) begin
                  wr_valid_q <= 1'b0;
                  if (last_row) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     row_q      <= row_q + RW'(1);
                     edge_req_q <= 1'b1;
                     state_q    <= S_REQ;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q     <= 1'b0;
               edge_req_q <= 1'b0;
               wr_valid_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.edge_req = edge_req_q;
   assign bus.edge_row = row_q;
   assign bus.wr_valid = wr_valid_q;
   assign bus.wr_row   = row_q;
   assign bus.wr_layer = layer_q;
   assign bus.wr_mask  = mask_q;
   assign bus.wr_data  = {ROW_PIX{color_q}};
endmodule
